// File: rtl/wisc_ctrl_pkg.sv
// Shared opcode/ALU encodings and the control-bundle layout for the WISC
// decode stage.
package wisc_ctrl_pkg;

    localparam int INST_W    = 16;
    localparam int OPC_W     = 4;
    localparam int REG_W     = 4;
    localparam int ALU_CMD_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD    = 4'h0;
    localparam logic [OPC_W-1:0] OP_PADDSB = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB    = 4'h2;
    localparam logic [OPC_W-1:0] OP_NAND   = 4'h3;
    localparam logic [OPC_W-1:0] OP_XOR    = 4'h4;
    localparam logic [OPC_W-1:0] OP_SLL    = 4'h5;
    localparam logic [OPC_W-1:0] OP_SRL    = 4'h6;
    localparam logic [OPC_W-1:0] OP_SRA    = 4'h7;
    localparam logic [OPC_W-1:0] OP_LW     = 4'h8;
    localparam logic [OPC_W-1:0] OP_SW     = 4'h9;
    localparam logic [OPC_W-1:0] OP_LHB    = 4'hA;
    localparam logic [OPC_W-1:0] OP_LLB    = 4'hB;
    localparam logic [OPC_W-1:0] OP_B      = 4'hC;
    localparam logic [OPC_W-1:0] OP_CALL   = 4'hD;
    localparam logic [OPC_W-1:0] OP_RET    = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT    = 4'hF;

    localparam logic [ALU_CMD_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [ALU_CMD_W-1:0] ALU_SUB    = 4'b0001;
    localparam logic [ALU_CMD_W-1:0] ALU_PADDSB = 4'b0010;
    localparam logic [ALU_CMD_W-1:0] ALU_XOR    = 4'b0100;
    localparam logic [ALU_CMD_W-1:0] ALU_NAND   = 4'b1000;
    localparam logic [ALU_CMD_W-1:0] ALU_SLL    = 4'b1100;
    localparam logic [ALU_CMD_W-1:0] ALU_SRL    = 4'b1110;
    localparam logic [ALU_CMD_W-1:0] ALU_SRA    = 4'b1111;

    typedef struct packed {
        logic [ALU_CMD_W-1:0] alu_cmd;
        logic                 alu_src;
        logic                 reg_wrt;
        logic                 mem_to_reg;
        logic                 mem_wrt;
        logic                 branch;
        logic                 call;
        logic                 ret;
        logic                 halt;
        logic                 set_over;
        logic                 set_zero;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder: control bundle plus which instruction
// fields are read as sources.
module ctrl_decode
    import wisc_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl,
    output logic             reads_rs,
    output logic             reads_rt,
    output logic             reads_rd
);

    always_comb begin
        ctrl = CTRL_BUBBLE;
        unique case (opcode)
            OP_ADD:    begin ctrl.alu_cmd = ALU_ADD;    ctrl.reg_wrt = 1'b1; ctrl.set_over = 1'b1; ctrl.set_zero = 1'b1; end
            OP_PADDSB: begin ctrl.alu_cmd = ALU_PADDSB; ctrl.reg_wrt = 1'b1; end
            OP_SUB:    begin ctrl.alu_cmd = ALU_SUB;    ctrl.reg_wrt = 1'b1; ctrl.set_over = 1'b1; ctrl.set_zero = 1'b1; end
            OP_NAND:   begin ctrl.alu_cmd = ALU_NAND;   ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; end
            OP_XOR:    begin ctrl.alu_cmd = ALU_XOR;    ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; end
            OP_SLL:    begin ctrl.alu_cmd = ALU_SLL;    ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_src = 1'b1; end
            OP_SRL:    begin ctrl.alu_cmd = ALU_SRL;    ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_src = 1'b1; end
            OP_SRA:    begin ctrl.alu_cmd = ALU_SRA;    ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_src = 1'b1; end
            OP_LW:     begin ctrl.reg_wrt = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_src = 1'b1; end
            OP_SW:     begin ctrl.mem_wrt = 1'b1; ctrl.alu_src = 1'b1; end
            OP_LHB:    ctrl.reg_wrt = 1'b1;
            OP_LLB:    ctrl.reg_wrt = 1'b1;
            OP_B:      ctrl.branch  = 1'b1;
            OP_CALL:   begin ctrl.reg_wrt = 1'b1; ctrl.call = 1'b1; end
            OP_RET:    ctrl.ret  = 1'b1;
            OP_HLT:    ctrl.halt = 1'b1;
            default:   ctrl = CTRL_BUBBLE;
        endcase
    end

    // SW and LHB use rd as a source (store data / upper-byte merge).
    assign reads_rs = (opcode <= OP_SW);
    assign reads_rt = (opcode <= OP_XOR);
    assign reads_rd = (opcode == OP_SW) || (opcode == OP_LHB);

endmodule

// File: rtl/ctrl_pipe.sv
// Registered decode/control stage: decodes ID, owns the ID/EX control
// register, load-use stall, flush, back-pressure and sticky halt.
module ctrl_pipe
    import wisc_ctrl_pkg::*;
#(
    parameter int INST_W    = wisc_ctrl_pkg::INST_W,
    parameter int OPC_W     = wisc_ctrl_pkg::OPC_W,
    parameter int REG_W     = wisc_ctrl_pkg::REG_W,
    parameter int ALU_CMD_W = wisc_ctrl_pkg::ALU_CMD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inst_valid,
    input  logic [INST_W-1:0]    inst,
    input  logic                 flush_i,
    input  logic                 ex_ready_i,
    output logic                 stall_o,
    output logic                 halted_o,
    output logic                 ex_valid,
    output logic [ALU_CMD_W-1:0] ex_alu_cmd,
    output logic                 ex_alu_src,
    output logic                 ex_reg_wrt,
    output logic                 ex_mem_to_reg,
    output logic                 ex_mem_wrt,
    output logic                 ex_branch,
    output logic                 ex_call,
    output logic                 ex_ret,
    output logic                 ex_halt,
    output logic                 ex_set_over,
    output logic                 ex_set_zero,
    output logic [REG_W-1:0]     ex_rd
);

    // ID/EX handshake: ex_valid marks a real instruction in ID/EX; it is
    // consumed on any edge where ex_ready_i=1, otherwise ID/EX holds.
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd, rs, rt;
    ctrl_t            dec_ctrl;
    logic             reads_rs, reads_rt, reads_rd;

    ctrl_t            ex_ctrl_q;
    logic             ex_valid_q;
    logic [REG_W-1:0] ex_rd_q;
    logic             halted_q;

    logic             hazard;
    logic             load_issue;
    logic             load_bubble;

    assign opcode = inst[INST_W-1 -: OPC_W];
    assign rd     = inst[3*REG_W-1 -: REG_W];
    assign rs     = inst[2*REG_W-1 -: REG_W];
    assign rt     = inst[REG_W-1:0];

    ctrl_decode u_decode (
        .opcode   (opcode),
        .ctrl     (dec_ctrl),
        .reads_rs (reads_rs),
        .reads_rt (reads_rt),
        .reads_rd (reads_rd)
    );

    // R0 is hardwired zero, so a load into it can never create a dependency.
    assign hazard = ex_valid_q && ex_ctrl_q.mem_to_reg && (ex_rd_q != '0) && inst_valid &&
                    ((reads_rs && (rs == ex_rd_q)) ||
                     (reads_rt && (rt == ex_rd_q)) ||
                     (reads_rd && (rd == ex_rd_q)));

    always_comb begin
        stall_o     = 1'b0;
        load_issue  = 1'b0;
        load_bubble = 1'b0;
        if (flush_i) begin
            load_bubble = 1'b1;
        end else if (!ex_ready_i) begin
            stall_o = 1'b1;
        end else if (halted_q || hazard) begin
            stall_o     = 1'b1;
            load_bubble = 1'b1;
        end else if (inst_valid) begin
            load_issue = 1'b1;
        end else begin
            load_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ctrl_q  <= CTRL_BUBBLE;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            if (load_issue) begin
                ex_ctrl_q  <= dec_ctrl;
                ex_valid_q <= 1'b1;
                ex_rd_q    <= rd;
            end else if (load_bubble) begin
                ex_ctrl_q  <= CTRL_BUBBLE;
                ex_valid_q <= 1'b0;
                ex_rd_q    <= '0;
            end
            // HLT takes effect only once EX has accepted it.
            if (ex_valid_q && ex_ctrl_q.halt && ex_ready_i) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign halted_o      = halted_q;
    assign ex_valid      = ex_valid_q;
    assign ex_alu_cmd    = ex_ctrl_q.alu_cmd;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_reg_wrt    = ex_ctrl_q.reg_wrt;
    assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign ex_mem_wrt    = ex_ctrl_q.mem_wrt;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_call       = ex_ctrl_q.call;
    assign ex_ret        = ex_ctrl_q.ret;
    assign ex_halt       = ex_ctrl_q.halt;
    assign ex_set_over   = ex_ctrl_q.set_over;
    assign ex_set_zero   = ex_ctrl_q.set_zero;
    assign ex_rd         = ex_rd_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed test-plan sequences followed by
// randomized traffic, checked against a rule-level reference model.
module tb_ctrl_pipe;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic [15:0] inst;
    logic        flush_i;
    logic        ex_ready_i;
    logic        stall_o;
    logic        halted_o;
    logic        ex_valid;
    logic [3:0]  ex_alu_cmd;
    logic        ex_alu_src, ex_reg_wrt, ex_mem_to_reg, ex_mem_wrt, ex_branch;
    logic        ex_call, ex_ret, ex_halt, ex_set_over, ex_set_zero;
    logic [3:0]  ex_rd;

    ctrl_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .flush_i       (flush_i),
        .ex_ready_i    (ex_ready_i),
        .stall_o       (stall_o),
        .halted_o      (halted_o),
        .ex_valid      (ex_valid),
        .ex_alu_cmd    (ex_alu_cmd),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_wrt    (ex_reg_wrt),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_mem_wrt    (ex_mem_wrt),
        .ex_branch     (ex_branch),
        .ex_call       (ex_call),
        .ex_ret        (ex_ret),
        .ex_halt       (ex_halt),
        .ex_set_over   (ex_set_over),
        .ex_set_zero   (ex_set_zero),
        .ex_rd         (ex_rd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // {halted, valid, alu[3:0], src,wrt, m2r,mwrt, br,call, ret,halt, ov,z, rd[3:0]}
    logic [19:0] exp_q[$];
    logic        started = 1'b0;

    // Control bits per opcode: alu | src,wrt | m2r,mwrt | br,call | ret,halt | ov,z
    logic [13:0] ctrl_tbl [16];
    initial begin
        ctrl_tbl[0]  = 14'b0000_01_00_00_00_11; // ADD
        ctrl_tbl[1]  = 14'b0010_01_00_00_00_00; // PADDSB
        ctrl_tbl[2]  = 14'b0001_01_00_00_00_11; // SUB
        ctrl_tbl[3]  = 14'b1000_01_00_00_00_01; // NAND
        ctrl_tbl[4]  = 14'b0100_01_00_00_00_01; // XOR
        ctrl_tbl[5]  = 14'b1100_11_00_00_00_01; // SLL
        ctrl_tbl[6]  = 14'b1110_11_00_00_00_01; // SRL
        ctrl_tbl[7]  = 14'b1111_11_00_00_00_01; // SRA
        ctrl_tbl[8]  = 14'b0000_11_10_00_00_00; // LW
        ctrl_tbl[9]  = 14'b0000_10_01_00_00_00; // SW
        ctrl_tbl[10] = 14'b0000_01_00_00_00_00; // LHB
        ctrl_tbl[11] = 14'b0000_01_00_00_00_00; // LLB
        ctrl_tbl[12] = 14'b0000_00_00_10_00_00; // B
        ctrl_tbl[13] = 14'b0000_01_00_01_00_00; // CALL
        ctrl_tbl[14] = 14'b0000_00_00_00_10_00; // RET
        ctrl_tbl[15] = 14'b0000_00_00_00_01_00; // HLT
    end

    // Reference model state: what instruction (if any) sits in ID/EX.
    logic       m_valid  = 1'b0;
    logic [3:0] m_op     = '0;
    logic [3:0] m_rd     = '0;
    logic       m_halted = 1'b0;
    logic       exp_stall = 1'b0;

    function automatic logic uses_reg(input logic [15:0] i, input logic [3:0] r);
        int op;
        op = int'(i[15:12]);
        return (op <= 9 && i[7:4] == r) || (op <= 4 && i[3:0] == r) ||
               ((op == 9 || op == 10) && i[11:8] == r);
    endfunction

    // driver: one cycle of stimulus, model update and expected push
    task automatic step(input logic v, input logic [15:0] i, input logic f,
                        input logic r, input logic rn);
        logic halt_set, hz;
        @(negedge clk);
        inst_valid = v; inst = i; flush_i = f; ex_ready_i = r; rst_n = rn;
        #1;
        if (!rn) begin
            m_valid = 1'b0; m_op = '0; m_rd = '0; m_halted = 1'b0; exp_stall = 1'b0;
        end else begin
            halt_set = m_valid && m_op == 4'hF && r;
            hz = m_valid && m_op == 4'h8 && m_rd != 4'd0 && v && uses_reg(i, m_rd);
            if (f) begin
                exp_stall = 1'b0; m_valid = 1'b0;
            end else if (!r) begin
                exp_stall = 1'b1;
            end else if (m_halted || hz) begin
                exp_stall = 1'b1; m_valid = 1'b0;
            end else if (v) begin
                exp_stall = 1'b0; m_valid = 1'b1; m_op = i[15:12]; m_rd = i[11:8];
            end else begin
                exp_stall = 1'b0; m_valid = 1'b0;
            end
            if (halt_set) m_halted = 1'b1;
            vectors++;
            if (stall_o !== exp_stall) begin
                miscompares++;
                $display("FAIL stall_o t=%0t inst=%h got %b exp %b", $time, i, stall_o, exp_stall);
            end
        end
        exp_q.push_back({m_halted, m_valid, (m_valid ? ctrl_tbl[m_op] : 14'd0),
                         (m_valid ? m_rd : 4'd0)});
        started = 1'b1;
    endtask

    // issue an instruction, holding it in ID while the model says stall
    task automatic issue(input logic [15:0] i);
        step(1'b1, i, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 8 && exp_stall; n++) step(1'b1, i, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [19:0] got, exp;
        #1;
        if (started) begin
            got = {halted_o, ex_valid, ex_alu_cmd, ex_alu_src, ex_reg_wrt, ex_mem_to_reg,
                   ex_mem_wrt, ex_branch, ex_call, ex_ret, ex_halt, ex_set_over,
                   ex_set_zero, ex_rd};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow t=%0t got %h exp none", $time, got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL ex_state t=%0t got %h exp %h", $time, got, exp);
                end
            end
        end
    end

    initial begin
        logic [15:0] cur;
        logic        cur_v;
        logic [3:0]  op;
        rst_n = 1'b0; inst_valid = 1'b0; inst = '0; flush_i = 1'b0; ex_ready_i = 1'b1;

        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        idle(1);

        // ADD R3,R1,R2
        issue(16'h0312); idle(2);
        // LW R4 then dependent ADD: one bubble
        issue(16'h8450); issue(16'h0541); idle(2);
        // LW R0 then "dependent" ADD: no stall
        issue(16'h8050); issue(16'h0501); idle(2);
        // SW R2 after LW R2 (rd-as-source), then B after LW R2
        issue(16'h8200); issue(16'h9210); idle(2);
        issue(16'h8200); issue(16'hC200); idle(2);
        // flush while load-use hazard present
        issue(16'h8450); step(1'b1, 16'h0541, 1'b1, 1'b1, 1'b1); idle(2);
        // back-pressure with SUB in ID/EX
        issue(16'h2312);
        for (int k = 0; k < 3; k++) step(1'b1, 16'h0541, 1'b0, 1'b0, 1'b1);
        idle(2);
        // HLT, then ADDs become bubbles, then reset
        issue(16'hF000); idle(1);
        for (int k = 0; k < 3; k++) step(1'b1, 16'h0312, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        idle(1);
        // HLT killed by flush never halts
        step(1'b1, 16'hF000, 1'b1, 1'b1, 1'b1); idle(3);
        issue(16'h0312); idle(1);

        // randomized traffic; ID holds its instruction while stalled
        cur = '0; cur_v = 1'b0;
        for (int c = 0; c < 800; c++) begin
            logic rn, f, r;
            if (!(exp_stall && cur_v)) begin
                op    = ($urandom_range(0, 9) < 3) ? 4'h8 : 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
                cur   = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                         4'($urandom_range(0, 3))};
                cur_v = ($urandom_range(0, 9) < 8);
            end
            rn = !(($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 7) == 0));
            f  = ($urandom_range(0, 11) == 0);
            r  = ($urandom_range(0, 5) != 0);
            step(cur_v, cur, f, r, rn);
            if (f || !rn) cur_v = 1'b0;
        end
        idle(2);

        @(posedge clk); #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
